// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction memory addressing and IF/ID register; FETCH_BOUND_CHECK_EN adds an out-of-range fetch fault
module fetch_stage #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter int                IMEM_LEN = 72
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  input  logic             i_halt,
  output logic [WIDTH-3:0] o_imem_add,
  input  logic [WIDTH-1:0] i_imem_data,
  output logic [WIDTH-1:0] o_if_instr,
  output logic [WIDTH-1:0] o_if_pc,
  output logic [WIDTH-1:0] o_if_pc_plus4,
  output logic             o_if_valid,
  output logic             o_fault
);
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, r_instr, r_if_pc, r_if_pc_plus4;
  logic             r_valid;
  logic             w_run, w_capture, w_oob;
  logic [WIDTH-1:0] w_pc_plus4, w_redirect_pc;
  if (IMEM_LEN < 4) begin : g_len_check
    $error("IMEM_LEN must cover at least one instruction word");
  end
  assign w_run         = r_state == S_RUN;
  assign w_capture     = w_run && !i_halt && !i_redirect && !i_stall;
  assign w_pc_plus4    = r_pc + WIDTH'(4);
  assign w_redirect_pc = i_redirect_pc & ~WIDTH'(3);
  assign o_imem_add    = r_pc[WIDTH-1:2];
  assign o_if_instr    = r_instr;
  assign o_if_pc       = r_if_pc;
  assign o_if_pc_plus4 = r_if_pc_plus4;
  assign o_if_valid    = r_valid;
`ifdef FETCH_BOUND_CHECK_EN
  logic r_fault;
  assign w_oob   = w_capture && (r_pc >= WIDTH'(IMEM_LEN));
  assign o_fault = r_fault;
  // sticky fault flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fault <= 1'b0;
    else if (w_oob) r_fault <= 1'b1;
  end
`else
  assign w_oob   = 1'b0;
  assign o_fault = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_BOOT;
    else r_state <= w_state_nxt;
  end
  // BOOT lasts one cycle; halt or an out-of-range capture parks the stage in HALT
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == S_BOOT) ? S_RUN :
                  (w_run && (i_halt || w_oob)) ? S_HALT : r_state;
  end
  // PC and IF/ID update in RUN: halt > redirect > stall > capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC & ~WIDTH'(3);
      r_instr       <= '0;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_valid       <= 1'b0;
    end else if (w_run) begin
      if (i_halt) r_valid <= 1'b0;
      else if (i_redirect) begin
        r_pc    <= w_redirect_pc;
        r_valid <= 1'b0;
      end else if (i_stall) r_valid <= r_valid & ~i_flush;
      else if (w_oob) r_valid <= 1'b0;
      else begin
        r_instr       <= i_imem_data;
        r_if_pc       <= r_pc;
        r_if_pc_plus4 <= w_pc_plus4;
        r_pc          <= w_pc_plus4;
        r_valid       <= ~i_flush;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage (mirrors FETCH_BOUND_CHECK_EN when defined)
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0, halt = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [29:0] imem_add;
  logic [31:0] imem_data, if_instr, if_pc, if_pc_plus4;
  logic        if_valid, fault;
  int          n_vec = 0, n_err = 0;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0), .IMEM_LEN(72)) dut (
    .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .i_halt(halt),
    .o_imem_add(imem_add), .i_imem_data(imem_data), .o_if_instr(if_instr),
    .o_if_pc(if_pc), .o_if_pc_plus4(if_pc_plus4), .o_if_valid(if_valid),
    .o_fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (a == 30'd0) return 32'h0000_0013;
    if (a == 30'd1) return 32'h0050_0093;
    if (a < 30'd18) return 32'h1000_0000 + 32'(a);
    return 32'hBAD0_0000 | {16'h0, a[15:0]};
  endfunction

  assign imem_data = mem_word(imem_add);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins, input logic v);
    chk({tag, ".pc"}, if_pc, pc);
    chk({tag, ".instr"}, if_instr, ins);
    chk({tag, ".plus4"}, if_pc_plus4, pc + 32'd4);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
  endtask

  task automatic redir(input logic [31:0] t);
    redirect = 1'b1; redirect_pc = t;
    tick;
    redirect = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst.valid", {31'd0, if_valid}, 32'd0);
    chk("rst.instr", if_instr, 32'd0);
    chk("rst.pc", if_pc, 32'd0);
    chk("rst.plus4", if_pc_plus4, 32'd0);
    chk("rst.fault", {31'd0, fault}, 32'd0);
    chk("rst.add", {2'b0, imem_add}, 32'd0);
    @(negedge clk); rst = 1'b0;
    tick;
    chk("boot.valid", {31'd0, if_valid}, 32'd0);
    chk("boot.add", {2'b0, imem_add}, 32'd0);
    tick;
    ifid("run0", 32'h0, 32'h0000_0013, 1'b1);
    chk("run0.add", {2'b0, imem_add}, 32'd1);
    tick;
    ifid("run1", 32'h4, 32'h0050_0093, 1'b1);
    chk("run1.add", {2'b0, imem_add}, 32'd2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall.add", {2'b0, imem_add}, 32'd2);
      ifid("stall", 32'h4, 32'h0050_0093, 1'b1);
    end
    stall = 1'b0;
    tick;
    ifid("unstall", 32'h8, 32'h1000_0002, 1'b1);
    stall = 1'b1;
    redir(32'h2E);
    stall = 1'b0;
    chk("redir.add", {2'b0, imem_add}, 32'd11);
    chk("redir.valid", {31'd0, if_valid}, 32'd0);
    tick;
    ifid("redir1", 32'h2C, 32'h1000_000B, 1'b1);
    redir(32'h10);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush.valid", {31'd0, if_valid}, 32'd0);
    chk("flush.add", {2'b0, imem_add}, 32'd5);
    chk("flush.pc", if_pc, 32'h10);
    tick;
    ifid("postflush", 32'h14, 32'h1000_0005, 1'b1);
    flush = 1'b1; stall = 1'b1;
    tick;
    flush = 1'b0; stall = 1'b0;
    ifid("flstall", 32'h14, 32'h1000_0005, 1'b0);
    chk("flstall.add", {2'b0, imem_add}, 32'd6);
    tick;
    ifid("flstall1", 32'h18, 32'h1000_0006, 1'b1);
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick;
    halt = 1'b0; redirect = 1'b0;
    chk("halt.add", {2'b0, imem_add}, 32'd7);
    ifid("halt", 32'h18, 32'h1000_0006, 1'b0);
    tick; tick;
    chk("halted.add", {2'b0, imem_add}, 32'd7);
    ifid("halted", 32'h18, 32'h1000_0006, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst.add", {2'b0, imem_add}, 32'd0);
    chk("arst.pc", if_pc, 32'd0);
    chk("arst.instr", if_instr, 32'd0);
    chk("arst.plus4", if_pc_plus4, 32'd0);
    tick;
    rst = 1'b0;
    tick;
    chk("boot2.valid", {31'd0, if_valid}, 32'd0);
    tick;
    ifid("rerun", 32'h0, 32'h0000_0013, 1'b1);
    redir(32'h48);
    tick;
`ifdef FETCH_BOUND_CHECK_EN
    chk("oob.fault", {31'd0, fault}, 32'd1);
    chk("oob.valid", {31'd0, if_valid}, 32'd0);
    chk("oob.add", {2'b0, imem_add}, 32'd18);
    tick;
    chk("oob.sticky", {31'd0, fault}, 32'd1);
    chk("oob.halted", {2'b0, imem_add}, 32'd18);
`else
    ifid("far", 32'h48, 32'hBAD0_0012, 1'b1);
    chk("far.fault", {31'd0, fault}, 32'd0);
    redir(32'hFFFF_FFFC);
    chk("wrap.add", {2'b0, imem_add}, 32'h3FFF_FFFF);
    tick;
    chk("wrap.pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap.plus4", if_pc_plus4, 32'd0);
    chk("wrap.add2", {2'b0, imem_add}, 32'd0);
    chk("wrap.valid", {31'd0, if_valid}, 32'd1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
